length_unpacking_unit: RTL
==========================

# length_unpacking_unit

Decompression-side counterpart of the length-packing stage. It accepts the 128-bit packed compressed stream and rebuilds the individual variable-length records from it. Each record is one 3-bit encoding field followed by a payload whose length that encoding fixes. The unit buffers stream bits across chunk boundaries, splits off one record per cycle, and hands `{encoded, length, payload}` to the decoder stage behind a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 64, maximum payload width and width of o_payload
- CHUNK_W, 128, width of one packed input chunk

Ports:
- i_clk  in  1  the single clock
- i_reset  in  1  reset, asynchronous, active-low
- i_valid  in  1  input chunk valid
- o_ready  out  1  unit can accept a chunk
- i_chunk  in  CHUNK_W  packed bits, MSB first (bit 127 is the oldest)
- i_last  in  1  marks the final chunk of a stream
- i_valid_bits  in  8  meaningful bits in the last chunk, 1..128 (ignored unless i_last)
- o_valid  out  1  record output valid
- i_ready  in  1  downstream accepts the record
- o_encoded  out  3  encoding field
- o_length  out  7  payload length in bits, 0..64
- o_payload  out  WIDTH  payload, right-aligned, upper bits zero
- o_done  out  1  one-cycle pulse once the last record of a stream has been accepted
- o_err  out  1  sticky framing error (see Configuration)

## Operation
- Payload length per encoding:
  - 0: 0 bits
  - 1: 4 bits
  - 2: 8 bits
  - 3: 16 bits
  - 4: 20 bits (4-bit location + 16)
  - 5: 32 bits
  - 6: 36 bits (4-bit location + 32)
  - 7: 64 bits
- Record size = 3 + payload length, maximum 67 bits.
- Bit buffer: 256 bits with a 9-bit occupancy counter `occ` (0..256). Bits are left-aligned; the oldest bit is buffer[255].
- o_ready = (state == S_FILL) && (occ <= 128). A chunk is accepted when i_valid && o_ready. It is appended directly below the current occupancy, and occ increases by 128. When i_last is set, occ increases by i_valid_bits instead and the bits below the valid ones are discarded.
- Pop: when the output register is empty or i_ready is high, and occ >= 3 and occ >= 3 + len(buffer[255:253]), the unit:
  - loads the record into the output register;
  - left-shifts the buffer by the record size;
  - reduces occ by the record size.
- Accept and pop in the same cycle are allowed: occ_next = occ − popped + appended. The new chunk is appended at the post-shift position.
- FSM:
  - S_FILL → S_DRAIN when the i_last chunk is accepted.
  - S_DRAIN pops the remaining records. When occ < 3, or occ is smaller than the size of the next record, the leftover bits are cleared (occ := 0). Once the output register has drained, the FSM moves to S_DONE.
  - S_DONE raises o_done for one cycle, then returns to S_FILL.
- Reset values: o_ready 0 during reset and 1 from the first cycle after it; o_valid 0; o_encoded 0; o_length 0; o_payload 0; o_done 0; o_err 0; occ 0; state S_FILL.
- Reset asserted mid-stream discards the buffer and the output register immediately.

## Timing
- Chunk accepted in cycle N → buffer updated at the N+1 edge → first record valid with o_valid high in cycle N+2.
- Sustained throughput: one record per cycle while `occ` is sufficient and i_ready is high.
- The output register holds o_valid and its data stable until i_ready.
- o_ready depends only on registered state; there is no combinational path from i_ready.
- o_done is asserted in the cycle after the final record handshake.

## Configuration
- LENGTH_UNPACK_CHECK_EN defined:
  - In S_DRAIN, a nonzero leftover that is too short for a complete record sets o_err.
  - An i_last chunk with i_valid_bits == 0 also sets o_err.
  - o_err stays set until reset.
- Undefined: o_err is tied to 0 and leftovers are discarded silently.

## Structure
- Package `length_unpack_pkg`:
  - constants BUF_W = 256, CHUNK_W = 128, ENC_W = 3, LEN_W = 7;
  - state enum `unpack_state_e` {S_FILL, S_DRAIN, S_DONE};
  - function `payload_len(enc)` implementing the encoding table.
- Sub-module `unpack_field_extract`: a combinational extractor that takes the buffer head, returns encoding, length and right-aligned payload, and contains the payload barrel shifter.

## Test plan
- Reset: hold i_reset low for 3 cycles → every output is 0; o_ready = 1 on the first cycle after release.
- Single record: a chunk with bits[127:125] = 3'b101, [124:93] = 32'hDEADBEEF, then i_last with i_valid_bits = 35 → one record with encoded 5, length 32, payload 64'h00000000DEADBEEF at N+2; o_done pulses one cycle after the handshake.
- Straddling record: a code-7 record starting at bit 40 of chunk 1, whose payload of 64'h0123456789ABCDEF continues into chunk 2 → the full payload is correct, and it is emitted only after chunk 2 is accepted.
- Back-to-back and backpressure:
  - stream of 32 code-1 records (7 bits each) with i_ready tied to 1 → one record per cycle;
  - i_ready toggled every other cycle → no record lost, output held stable while stalled, o_ready drops while occ > 128.
- Zero-payload and simultaneity: consecutive code-0 records emitted while a chunk is accepted in the same cycle → occ is updated correctly and no record is duplicated.
- Framing error: with LENGTH_UNPACK_CHECK_EN defined, the last chunk leaves 2 stray bits → o_err rises in S_DRAIN and stays high. Without the macro, o_err stays 0 and o_done still pulses.

Source files
------------

// File: rtl/length_unpack_pkg.sv
// ----------------------------------------------------------------------------
// length_unpack_pkg
// Shared constants, types and the encoding-to-length table for the
// length-unpacking stage (decompression side of the length packer).
//
// Contents:
//   BUF_W / CHUNK_W / ENC_W / LEN_W : buffer, chunk, encoding and length widths
//   OCC_W                           : width of the buffer occupancy counter
//   HEAD_W                          : bits of the buffer head one record can span
//   MAX_PAY                         : widest payload any encoding can carry
//   unpack_state_e                  : control FSM states
//   unpack_ctrl_t                   : FSM state + occupancy, kept together so the
//                                     whole control word is visible as one signal
//   payload_len()                   : payload bits carried by each encoding
// ----------------------------------------------------------------------------
package length_unpack_pkg;

  localparam int BUF_W   = 256;
  localparam int CHUNK_W = 128;
  localparam int ENC_W   = 3;
  localparam int LEN_W   = 7;
  localparam int OCC_W   = 9;
  localparam int MAX_PAY = 64;
  localparam int HEAD_W  = ENC_W + MAX_PAY;  // 67: the largest record

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } unpack_state_e;

  typedef struct packed {
    unpack_state_e          state;
    logic [OCC_W-1:0]       occ;
  } unpack_ctrl_t;

  // Encodings 4 and 6 carry a 4-bit location ahead of the 16/32-bit value;
  // the location travels inside the payload, so only the total length matters.
  function automatic logic [LEN_W-1:0] payload_len(input logic [ENC_W-1:0] enc);
    logic [LEN_W-1:0] len;
    case (enc)
      3'd0:    len = 7'd0;
      3'd1:    len = 7'd4;
      3'd2:    len = 7'd8;
      3'd3:    len = 7'd16;
      3'd4:    len = 7'd20;
      3'd5:    len = 7'd32;
      3'd6:    len = 7'd36;
      default: len = 7'd64;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/unpack_field_extract.sv
// ----------------------------------------------------------------------------
// unpack_field_extract
// Combinational record decoder for the head of the unpacking bit buffer.
// The head is MSB-first: [66:64] is the encoding, the payload follows
// immediately below it. The payload is right-aligned by a barrel shifter.
//
// Ports:
//   head_i    : top HEAD_W bits of the bit buffer (oldest bit at the MSB)
//   enc_o     : encoding field of the record at the head
//   len_o     : payload length in bits for that encoding
//   size_o    : full record size (encoding + payload) in bits
//   payload_o : payload, right-aligned, unused upper bits zero
// ----------------------------------------------------------------------------
module unpack_field_extract
  import length_unpack_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [HEAD_W-1:0] head_i,
  output logic [ENC_W-1:0]  enc_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [LEN_W-1:0]  size_o,
  output logic [WIDTH-1:0]  payload_o
);

  logic [MAX_PAY-1:0] body;
  logic [MAX_PAY-1:0] aligned;
  logic [LEN_W-1:0]   rshift;

  always_comb begin
    enc_o  = head_i[HEAD_W-1 -: ENC_W];
    len_o  = payload_len(enc_o);
    size_o = len_o + 7'd3;
    body   = head_i[MAX_PAY-1:0];
    // The payload occupies the top len bits of body; shifting right by
    // (64 - len) right-aligns it. len == 0 shifts by 64 and yields zero.
    rshift    = 7'(MAX_PAY) - len_o;
    aligned   = body >> rshift;
    payload_o = WIDTH'(aligned);
  end

endmodule

// File: rtl/length_unpacking_unit.sv
// ----------------------------------------------------------------------------
// length_unpacking_unit
// Rebuilds variable-length records {encoding, payload} from the packed
// 128-bit compressed stream. Incoming chunks are appended into a 256-bit
// left-aligned bit buffer; one record per cycle is split off the head into
// an output register.
//
// Optional feature macro: LENGTH_UNPACK_CHECK_EN
//   defined   : o_err is a sticky framing error (stray leftover bits at the end
//               of a stream, or a final chunk announcing zero valid bits)
//   undefined : o_err is tied low and leftovers are discarded silently
//
// Ports:
//   i_clk, i_reset : clock, asynchronous active-low reset
//   i_valid/o_ready: input chunk handshake; i_chunk MSB first, i_last marks the
//                    final chunk, i_valid_bits (1..128) its meaningful bits
//   o_valid/i_ready: record handshake; o_encoded, o_length, o_payload
//   o_done         : one-cycle pulse after the final record of a stream left
//   o_err          : sticky framing error (see macro above)
//
// Handshake semantics (both sides): a transfer happens in a cycle where valid
// and ready are both high at the clock edge. A valid producer keeps valid and
// data stable until that edge. o_ready is a register and has no combinational
// dependence on i_valid or i_ready.
// ----------------------------------------------------------------------------
module length_unpacking_unit #(
  parameter int WIDTH   = 64,
  parameter int CHUNK_W = 128
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [CHUNK_W-1:0] i_chunk,
  input  logic               i_last,
  input  logic [7:0]         i_valid_bits,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2:0]         o_encoded,
  output logic [6:0]         o_length,
  output logic [WIDTH-1:0]   o_payload,
  output logic               o_done,
  output logic               o_err
);

  import length_unpack_pkg::*;

  unpack_ctrl_t       ctrl_q, ctrl_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               ready_q, ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ENC_W-1:0]   enc_q, enc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [WIDTH-1:0]   payload_q, payload_d;

  logic [ENC_W-1:0]   head_enc;
  logic [LEN_W-1:0]   head_len;
  logic [LEN_W-1:0]   head_size;
  logic [WIDTH-1:0]   head_payload;

  logic               occ_ok;
  logic               out_free;
  logic               pop;
  logic               accept;
  logic [7:0]         vb_eff;
  logic [CHUNK_W-1:0] keep_mask;
  logic [OCC_W-1:0]   add_bits;
  logic [BUF_W-1:0]   post_pop_buf;
  logic [OCC_W-1:0]   post_pop_occ;
  logic [BUF_W-1:0]   chunk_placed;

  unpack_field_extract #(.WIDTH(WIDTH)) u_extract (
    .head_i    (buf_q[BUF_W-1 -: HEAD_W]),
    .enc_o     (head_enc),
    .len_o     (head_len),
    .size_o    (head_size),
    .payload_o (head_payload)
  );

  // A complete record sits at the head (size >= 3 covers the occ >= 3 rule,
  // kept explicit so the head is never decoded from stale bits).
  assign occ_ok   = (ctrl_q.occ >= 9'd3) && (ctrl_q.occ >= {2'b00, head_size});
  assign out_free = !out_valid_q || i_ready;
  assign pop      = (ctrl_q.state != S_DONE) && out_free && occ_ok;
  assign accept   = i_valid && ready_q;

  // Out-of-range valid-bit counts are treated as a full chunk so occ never
  // overflows the buffer.
  assign vb_eff    = (i_valid_bits > 8'd128) ? 8'd128 : i_valid_bits;
  assign keep_mask = i_last ? ~({CHUNK_W{1'b1}} >> vb_eff) : {CHUNK_W{1'b1}};
  assign add_bits  = i_last ? {1'b0, vb_eff} : 9'(CHUNK_W);

  // The new chunk lands directly below the bits that survive this cycle's pop.
  assign post_pop_buf = pop ? (buf_q << head_size) : buf_q;
  assign post_pop_occ = pop ? (ctrl_q.occ - {2'b00, head_size}) : ctrl_q.occ;
  assign chunk_placed = {i_chunk & keep_mask, {(BUF_W-CHUNK_W){1'b0}}} >> post_pop_occ;

  always_comb begin
    ctrl_d      = ctrl_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    enc_d       = enc_q;
    len_d       = len_q;
    payload_d   = payload_q;

    if (pop) begin
      out_valid_d = 1'b1;
      enc_d       = head_enc;
      len_d       = head_len;
      payload_d   = head_payload;
      buf_d       = post_pop_buf;
      ctrl_d.occ  = post_pop_occ;
    end else if (i_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      buf_d      = post_pop_buf | chunk_placed;
      ctrl_d.occ = post_pop_occ + add_bits;
    end

    case (ctrl_q.state)
      S_FILL: begin
        if (accept && i_last) ctrl_d.state = S_DRAIN;
      end
      S_DRAIN: begin
        // No complete record left: drop the tail, then finish once the
        // output register is empty or is being taken this cycle.
        if (!occ_ok) begin
          buf_d      = '0;
          ctrl_d.occ = '0;
          if (out_free) ctrl_d.state = S_DONE;
        end
      end
      S_DONE: begin
        ctrl_d.state = S_FILL;
      end
      default: begin
        ctrl_d.state = S_FILL;
      end
    endcase

    // Registered ready: computed from next state so it is already correct in
    // the cycle it applies to, and stays low while reset is held.
    ready_d = (ctrl_d.state == S_FILL) && (ctrl_d.occ <= 9'd128);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_q      <= '{state: S_FILL, occ: '0};
      buf_q       <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      enc_q       <= '0;
      len_q       <= '0;
      payload_q   <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      buf_q       <= buf_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      enc_q       <= enc_d;
      len_q       <= len_d;
      payload_q   <= payload_d;
    end
  end

`ifdef LENGTH_UNPACK_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((ctrl_q.state == S_FILL) && accept && i_last && (i_valid_bits == 8'd0))
      err_d = 1'b1;
    if ((ctrl_q.state == S_DRAIN) && !occ_ok && (ctrl_q.occ != '0))
      err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_ready   = ready_q;
  assign o_valid   = out_valid_q;
  assign o_encoded = enc_q;
  assign o_length  = len_q;
  assign o_payload = payload_q;
  assign o_done    = (ctrl_q.state == S_DONE);

endmodule
